wspr_symbol_sequencer: RTL and testbench
========================================

// Module: wspr_symbol_sequencer
// PURPOSE
//  Upstream feeder for the 200 Msps NCO: steps a 162-symbol 4-FSK WSPR message into a 32-bit
//  tuning word. Firmware loads symbols, base and tone-step words over SPI regs, arms; TX starts
//  on next PPS edge, one symbol per periodClocks ticks (PPS-calibrated), word 0 (carrier off) idle.
// PARAMETERS
//  NUM_SYMBOLS   162  symbols per transmission (1..256)
//  ADDR_W        8    symbol RAM address width; 2**ADDR_W >= NUM_SYMBOLS
// PORTS
//  clk25MHz      in   1   TCXO clock; all logic on rising edge
//  nReset        in   1   asynchronous active-low reset
//  symWrEn       in   1   symbol RAM write strobe
//  symWrAddr     in   8   symbol index to write
//  symWrData     in   2   tone 0..3
//  baseWord      in   32  tuning word for tone 0
//  toneStep      in   32  tuning word increment per tone (~1.4648 Hz)
//  periodClocks  in   32  clk25MHz ticks per symbol (nominal 17066667)
//  arm           in   1   1-cycle pulse: start TX at next ppsEdge
//  abort         in   1   1-cycle pulse: stop immediately
//  ppsEdge       in   1   1-cycle synchronised PPS rising-edge pulse
//  tuningWord    out  32  word to NCO shadow register
//  txActive      out  1   high while symbols are being sent
//  armed         out  1   high while waiting for PPS
//  symbolIndex   out  8   index of symbol currently driving tuningWord
//  txDone        out  1   1-cycle pulse after last symbol period completes
// BEHAVIOUR
//  Reset: state IDLE; tuningWord=0, txActive=0, armed=0, symbolIndex=0, txDone=0; counters 0.
//   Symbol RAM contents not reset (undefined until written).
//  States: IDLE -> ARMED on arm; ARMED -> TX on ppsEdge; TX -> IDLE after symbol NUM_SYMBOLS-1
//   period ends (txDone pulses that cycle); abort from ARMED or TX -> IDLE next cycle.
//  arm while ARMED or TX ignored. arm and abort same cycle: abort wins.
//  ppsEdge in same cycle as arm not taken; needs armed=1 already.
//  TX entry: latch baseWord, toneStep, max(periodClocks,1) into shadows; inputs changing mid-TX
//   have no effect until next TX. symbolIndex=0, period counter=0.
//  tuningWord = baseShadow + sym*stepShadow, mod 2**32 (wrap, no saturation); sym read from RAM
//   at symbolIndex. Registered: tuningWord valid 1 cycle after TX entry / symbol advance.
//   sym*step built as shift-add (sym<=3), no multiplier.
//  Period counter counts 0..periodShadow-1; at terminal count: symbolIndex++ (or finish if last).
//   Each symbol therefore drives tuningWord exactly periodShadow cycles (first symbol offset
//   by the 1-cycle RAM/add latency; same offset applies to finish, so all durations equal).
//  TX end / abort: tuningWord=0, txActive=0, symbolIndex=0 in the same update cycle.
//  txActive high from TX entry cycle+1 until finish cycle+1; armed high in ARMED only.
//  RAM writes: ignored while txActive=1 or symWrAddr>=NUM_SYMBOLS; otherwise write-first,
//   visible to next TX. ppsEdge during TX ignored (no resync).
//  nReset asserted mid-TX: outputs return to reset values immediately (async), state IDLE.
// TESTING  (NUM_SYMBOLS=4, periodClocks=10 unless noted)
//  1 Load syms 0,1,2,3; base=0x1000_0000, step=0x10; arm, ppsEdge -> tuningWord 0x10000000,
//    0x10000010, 0x10000020, 0x10000030 each held 10 cycles, then 0, txDone 1 pulse, 40 TX cycles.
//  2 base=0xFFFF_FFF0, step=0x10, sym 3 -> tuningWord 0x0000_0020 (wrap).
//  3 abort at cycle 15 of TX -> next cycle tuningWord=0, txActive=0, no txDone; arm same cycle as
//    ppsEdge -> stays ARMED; arm+abort same cycle -> stays IDLE.
//  4 periodClocks=0 -> each symbol held 1 cycle; periodClocks changed to 50 mid-TX -> still 10.
//  5 symWrEn during TX to addr 1 and to addr 200 when idle -> RAM unchanged; next TX uses old sym.
//  6 nReset low mid-symbol 2 -> all outputs 0 immediately; after release, arm+ppsEdge restarts at 0.

Source files
------------

// File: rtl/wspr_symbol_sequencer.sv
// WSPR symbol sequencer: steps a stored 4-FSK symbol list into NCO tuning words,
// one symbol per PPS-calibrated period, starting on the PPS edge after arming.
module wspr_symbol_sequencer #(
    parameter int NUM_SYMBOLS = 162,
    parameter int ADDR_W      = 8
) (
    input  logic              clk25MHz,
    input  logic              nReset,
    input  logic              symWrEn,
    input  logic [ADDR_W-1:0] symWrAddr,
    input  logic [1:0]        symWrData,
    input  logic [31:0]       baseWord,
    input  logic [31:0]       toneStep,
    input  logic [31:0]       periodClocks,
    input  logic              arm,
    input  logic              abort,
    input  logic              ppsEdge,
    output logic [31:0]       tuningWord,
    output logic              txActive,
    output logic              armed,
    output logic [ADDR_W-1:0] symbolIndex,
    output logic              txDone
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_TX    = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   NUM_SYM_W = NUM_SYMBOLS[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_SYMBOLS - 1);

    // sym*step for a 2-bit tone, built from at most two shifted adds
    function automatic logic [31:0] tone_offset(input logic [1:0] sym, input logic [31:0] step);
        logic [31:0] v_lo;
        logic [31:0] v_hi;
        v_lo = sym[0] ? step : 32'd0;
        v_hi = sym[1] ? {step[30:0], 1'b0} : 32'd0;
        return v_lo + v_hi;
    endfunction

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_base;
    logic [31:0]        r_step;
    logic [31:0]        r_period;
    logic [31:0]        r_cnt;
    logic [ADDR_W-1:0]  r_idx;
    logic               r_fin;
    logic [1:0]         r_mem [2**ADDR_W];

    logic               w_term;
    logic               w_last;
    logic               w_tx_start;
    logic               w_finish;
    logic               w_run;
    logic               w_wr_ok;
    logic [1:0]         w_sym;
    logic [31:0]        w_word;

    // Decode of counter terminal count, start/finish conditions and the next tuning word
    always_comb begin
        w_term     = (r_cnt == (r_period - 32'd1));
        w_last     = (r_idx == LAST_IDX);
        w_tx_start = (r_state == S_ARMED) && ppsEdge && !abort;
        w_run      = (r_state == S_TX) && !abort;
        w_finish   = w_run && w_term && w_last;
        w_sym      = r_mem[r_idx];
        w_word     = r_base + tone_offset(w_sym, r_step);
        w_wr_ok    = symWrEn && !txActive && (r_state != S_TX)
                     && ({1'b0, symWrAddr} < NUM_SYM_W);
    end

    // State register
    always_ff @(posedge clk25MHz or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort always takes priority over arm and PPS
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (arm && !abort) begin
                    w_next_state = S_ARMED;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ARMED: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (ppsEdge) begin
                    w_next_state = S_TX;
                end else begin
                    w_next_state = S_ARMED;
                end
            end
            S_TX: begin
                if (abort || (w_term && w_last)) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_TX;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Shadow registers, period counter and symbol index
    always_ff @(posedge clk25MHz or negedge nReset) begin
        if (!nReset) begin
            r_base   <= 32'd0;
            r_step   <= 32'd0;
            r_period <= 32'd0;
            r_cnt    <= 32'd0;
            r_idx    <= '0;
        end else if (w_tx_start) begin
            r_base   <= baseWord;
            r_step   <= toneStep;
            r_period <= (periodClocks == 32'd0) ? 32'd1 : periodClocks;
            r_cnt    <= 32'd0;
            r_idx    <= '0;
        end else if (w_run) begin
            if (w_term) begin
                r_cnt <= 32'd0;
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end else begin
            r_cnt <= 32'd0;
            r_idx <= '0;
        end
    end

    // Registered outputs; they trail the counter by one cycle so every symbol,
    // including the last, is held for exactly one full period
    always_ff @(posedge clk25MHz or negedge nReset) begin
        if (!nReset) begin
            tuningWord  <= 32'd0;
            txActive    <= 1'b0;
            armed       <= 1'b0;
            symbolIndex <= '0;
            txDone      <= 1'b0;
            r_fin       <= 1'b0;
        end else begin
            armed <= (w_next_state == S_ARMED);
            r_fin <= w_finish;
            if (w_run) begin
                tuningWord  <= w_word;
                txActive    <= 1'b1;
                symbolIndex <= r_idx;
                txDone      <= 1'b0;
            end else begin
                tuningWord  <= 32'd0;
                txActive    <= 1'b0;
                symbolIndex <= '0;
                txDone      <= r_fin;
            end
        end
    end

    // Symbol RAM: not reset, locked while a transmission is in progress
    always_ff @(posedge clk25MHz) begin
        if (w_wr_ok) begin
            r_mem[symWrAddr] <= symWrData;
        end
    end

endmodule

// File: tb/tb_wspr_symbol_sequencer.sv
// Randomised self-checking bench for wspr_symbol_sequencer (NUM_SYMBOLS=4) against
// a per-cycle trace model derived from the symbol list and period.
module tb_wspr_symbol_sequencer;

    logic        clk25MHz = 1'b0;
    logic        nReset;
    logic        symWrEn;
    logic [7:0]  symWrAddr;
    logic [1:0]  symWrData;
    logic [31:0] baseWord;
    logic [31:0] toneStep;
    logic [31:0] periodClocks;
    logic        arm;
    logic        abort;
    logic        ppsEdge;
    logic [31:0] tuningWord;
    logic        txActive;
    logic        armed;
    logic [7:0]  symbolIndex;
    logic        txDone;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]  m_syms [4];
    logic [31:0] m_base;
    logic [31:0] m_step;
    logic [31:0] m_per;
    logic [41:0] obs [64];
    int          ncap;

    wspr_symbol_sequencer #(.NUM_SYMBOLS(4), .ADDR_W(8)) dut (
        .clk25MHz(clk25MHz), .nReset(nReset), .symWrEn(symWrEn), .symWrAddr(symWrAddr),
        .symWrData(symWrData), .baseWord(baseWord), .toneStep(toneStep),
        .periodClocks(periodClocks), .arm(arm), .abort(abort), .ppsEdge(ppsEdge),
        .tuningWord(tuningWord), .txActive(txActive), .armed(armed),
        .symbolIndex(symbolIndex), .txDone(txDone)
    );

    always #5 clk25MHz = ~clk25MHz;

    task automatic tick();
        @(posedge clk25MHz);
        #1;
    endtask

    // Expected {tuningWord, txActive, symbolIndex, txDone} k cycles after the PPS edge
    function automatic logic [41:0] exp_vec(input int k);
        int pe;
        int s;
        pe = (m_per == 32'd0) ? 1 : int'(m_per);
        if (k >= 1 && k <= 4 * pe) begin
            s = (k - 1) / pe;
            return {m_base + m_step * {30'd0, m_syms[s]}, 1'b1, 8'(s), 1'b0};
        end else if (k == 4 * pe + 1) begin
            return {32'd0, 1'b0, 8'd0, 1'b1};
        end else begin
            return 42'd0;
        end
    endfunction

    task automatic load_syms();
        for (int i = 0; i < 4; i++) begin
            symWrEn = 1'b1; symWrAddr = 8'(i); symWrData = m_syms[i];
            tick();
        end
        symWrEn = 1'b0;
    endtask

    task automatic start_tx();
        baseWord = m_base; toneStep = m_step; periodClocks = m_per;
        arm = 1'b1;
        tick();
        arm = 1'b0; ppsEdge = 1'b1;
        tick();
        ppsEdge = 1'b0;
    endtask

    // Runs one transmission, disturbing inputs and RAM mid-TX, recording outputs per cycle
    task automatic run_tx();
        int pe;
        pe = (m_per == 32'd0) ? 1 : int'(m_per);
        ncap = 4 * pe + 4;
        start_tx();
        for (int k = 1; k <= ncap; k++) begin
            tick();
            obs[k] = {tuningWord, txActive, symbolIndex, txDone};
            if (k == 3) begin
                periodClocks = 32'd50; baseWord = $urandom; toneStep = $urandom;
                symWrEn = 1'b1; symWrAddr = 8'($urandom_range(0, 3)); symWrData = 2'($urandom);
            end else begin
                symWrEn = 1'b0;
            end
        end
        symWrEn = 1'b0;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        tick(); tick();
        n_tests++; if (tuningWord !== 32'd0) begin n_fail++; $display("FAIL reset_tw got %h exp 0", tuningWord); end
        n_tests++; if (txActive !== 1'b0) begin n_fail++; $display("FAIL reset_act got %b exp 0", txActive); end
        n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL reset_armed got %b exp 0", armed); end
        n_tests++; if (symbolIndex !== 8'd0) begin n_fail++; $display("FAIL reset_idx got %0d exp 0", symbolIndex); end
        n_tests++; if (txDone !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", txDone); end
        nReset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int act_cnt;
        int done_cnt;
        m_syms = '{2'd0, 2'd1, 2'd2, 2'd3};
        m_base = 32'h1000_0000; m_step = 32'h10; m_per = 32'd10;
        load_syms();
        run_tx();
        act_cnt = 0; done_cnt = 0;
        for (int k = 1; k <= ncap; k++) begin
            n_tests++;
            if (obs[k] !== exp_vec(k)) begin
                n_fail++; $display("FAIL basic_cycle%0d got %h exp %h", k, obs[k], exp_vec(k));
            end
            act_cnt += int'(obs[k][9]);
            done_cnt += int'(obs[k][0]);
        end
        n_tests++; if (act_cnt != 40) begin n_fail++; $display("FAIL basic_active_cycles got %0d exp 40", act_cnt); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d exp 1", done_cnt); end
    endtask

    task automatic test_wrap();
        m_syms = '{2'd3, 2'd0, 2'd2, 2'd1};
        m_base = 32'hFFFF_FFF0; m_step = 32'h10; m_per = 32'd3;
        load_syms();
        run_tx();
        n_tests++;
        if (obs[1][41:10] !== 32'h0000_0020) begin
            n_fail++; $display("FAIL wrap_tw got %h exp 00000020", obs[1][41:10]);
        end
        for (int k = 1; k <= ncap; k++) begin
            n_tests++;
            if (obs[k] !== exp_vec(k)) begin
                n_fail++; $display("FAIL wrap_cycle%0d got %h exp %h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < 4; i++) m_syms[i] = 2'($urandom);
            m_base = $urandom; m_step = $urandom;
            m_per = (it == 0) ? 32'd0 : 32'($urandom_range(1, 9));
            load_syms();
            run_tx();
            for (int k = 1; k <= ncap; k++) begin
                n_tests++;
                if (obs[k] !== exp_vec(k)) begin
                    n_fail++; $display("FAIL rand%0d_p%0d_cycle%0d got %h exp %h", it, m_per, k, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_abort();
        int done_cnt;
        m_per = 32'd10;
        start_tx();
        for (int k = 1; k <= 15; k++) tick();
        n_tests++; if (txActive !== 1'b1) begin n_fail++; $display("FAIL abort_pre_act got %b exp 1", txActive); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++; if (tuningWord !== 32'd0) begin n_fail++; $display("FAIL abort_tw got %h exp 0", tuningWord); end
        n_tests++; if (txActive !== 1'b0) begin n_fail++; $display("FAIL abort_act got %b exp 0", txActive); end
        n_tests++; if (symbolIndex !== 8'd0) begin n_fail++; $display("FAIL abort_idx got %0d exp 0", symbolIndex); end
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            done_cnt += int'(txDone);
            tick();
        end
        n_tests++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_no_done got %0d exp 0", done_cnt); end
        arm = 1'b1; ppsEdge = 1'b1;
        tick();
        arm = 1'b0; ppsEdge = 1'b0;
        tick(); tick();
        n_tests++; if (armed !== 1'b1) begin n_fail++; $display("FAIL arm_pps_armed got %b exp 1", armed); end
        n_tests++; if (txActive !== 1'b0) begin n_fail++; $display("FAIL arm_pps_act got %b exp 0", txActive); end
        ppsEdge = 1'b1;
        tick();
        ppsEdge = 1'b0;
        tick();
        n_tests++; if (txActive !== 1'b1) begin n_fail++; $display("FAIL pps_start_act got %b exp 1", txActive); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        tick();
        n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL arm_abort_armed got %b exp 0", armed); end
        arm = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL abort_armed got %b exp 0", armed); end
    endtask

    task automatic test_ram_protect();
        m_syms = '{2'd1, 2'd2, 2'd3, 2'd0};
        m_base = 32'h0200_0000; m_step = 32'h0000_0100; m_per = 32'd4;
        load_syms();
        m_syms[2] = 2'd1;
        symWrEn = 1'b1; symWrAddr = 8'd2; symWrData = 2'd1;
        tick();
        symWrAddr = 8'd200; symWrData = 2'd3;
        tick();
        symWrEn = 1'b0;
        start_tx();
        for (int k = 1; k <= 20; k++) begin
            tick();
            obs[k] = {tuningWord, txActive, symbolIndex, txDone};
            symWrEn = (k == 2) ? 1'b1 : 1'b0; symWrAddr = 8'd1; symWrData = ~m_syms[1];
        end
        symWrEn = 1'b0;
        run_tx();
        for (int k = 1; k <= ncap; k++) begin
            n_tests++;
            if (obs[k] !== exp_vec(k)) begin
                n_fail++; $display("FAIL ram_protect_cycle%0d got %h exp %h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_async_reset();
        m_per = 32'd10;
        start_tx();
        for (int k = 1; k <= 25; k++) tick();
        n_tests++;
        if ({tuningWord, txActive, symbolIndex, txDone} !== exp_vec(25)) begin
            n_fail++; $display("FAIL prereset_vec got %h exp %h", {tuningWord, txActive, symbolIndex, txDone}, exp_vec(25));
        end
        #2 nReset = 1'b0;
        #1;
        n_tests++;
        if ({tuningWord, txActive, armed, symbolIndex, txDone} !== 43'd0) begin
            n_fail++; $display("FAIL async_reset_outputs got %h exp 0", {tuningWord, txActive, armed, symbolIndex, txDone});
        end
        tick();
        nReset = 1'b1;
        tick();
        run_tx();
        for (int k = 1; k <= ncap; k++) begin
            n_tests++;
            if (obs[k] !== exp_vec(k)) begin
                n_fail++; $display("FAIL post_reset_cycle%0d got %h exp %h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    initial begin
        symWrEn = 1'b0; symWrAddr = 8'd0; symWrData = 2'd0;
        baseWord = 32'd0; toneStep = 32'd0; periodClocks = 32'd10;
        arm = 1'b0; abort = 1'b0; ppsEdge = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_random();
        test_abort();
        test_ram_protect();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
